// File: rtl/plate_box_overlay_pkg.sv
// Shared definitions for the plate-location video path.
//   - coordinate / pixel widths and the 13-bit difference width used for
//     overflow-free geometry arithmetic
//   - scan-window constants and standard overlay colours
//   - box_t: the four box edges as one packed bundle
//   - abs_diff(): |a-b| of two coordinates, computed in 13 bits
package plate_pkg;

  localparam int COORD_W = 12;
  localparam int RGB_W   = 24;
  localparam int DIFF_W  = COORD_W + 1;

  // Character-search window used by the upstream location stage.
  localparam logic [COORD_W-1:0] POST_UP    = 12'd0;
  localparam logic [COORD_W-1:0] POST_DOWN  = 12'd479;
  localparam logic [COORD_W-1:0] POST_LEFT  = 12'd0;
  localparam logic [COORD_W-1:0] POST_RIGHT = 12'd799;

  localparam logic [RGB_W-1:0] C_RED   = 24'hFF0000;
  localparam logic [RGB_W-1:0] C_GREEN = 24'h00FF00;

  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] up;
    logic [COORD_W-1:0] down;
  } box_t;

  // Zero-extend, subtract, then fold the sign: range 0..4095 fits in 13 bits.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [DIFF_W-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DIFF_W-1] ? (~d + DIFF_W'(1)) : d;
  endfunction

endpackage

// File: rtl/plate_box_overlay_stability.sv
// box_stability_filter: latches the box edges once per frame and decides
// whether the box is geometrically valid and stable enough to draw.
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   i_vs           vertical sync, high = active frame; rising edge latches
//   i_edges        live box edges from the character-location stage
//   o_box          edges latched at the most recent vs rise
//   o_box_on       stable count reached STABLE_FRAMES
module box_stability_filter
  import plate_pkg::*;
#(
  parameter int MIN_W         = 40,
  parameter int MAX_W         = 380,
  parameter int MIN_H         = 20,
  parameter int JITTER        = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vs,
  input  box_t i_edges,
  output box_t o_box,
  output logic o_box_on
);

  localparam logic [DIFF_W-1:0] MIN_W_D  = DIFF_W'(MIN_W);
  localparam logic [DIFF_W-1:0] MAX_W_D  = DIFF_W'(MAX_W);
  localparam logic [DIFF_W-1:0] MIN_H_D  = DIFF_W'(MIN_H);
  localparam logic [DIFF_W-1:0] JITTER_D = DIFF_W'(JITTER);
  localparam logic [3:0]        SF       = 4'(STABLE_FRAMES);

  logic              r_vs_prev;
  logic              r_latch;    // one cycle after capture: cur/prev are settled
  box_t              r_cur;
  box_t              r_prev;
  logic [3:0]        r_cnt;

  logic              w_rise;
  logic [DIFF_W-1:0] w_width;
  logic [DIFF_W-1:0] w_height;
  logic              w_valid;
  logic              w_stable;
  logic [3:0]        w_cnt_next;

  assign w_rise = i_vs & ~r_vs_prev;

  always_comb begin
    w_width  = {1'b0, r_cur.right} - {1'b0, r_cur.left};
    w_height = {1'b0, r_cur.down}  - {1'b0, r_cur.up};
    // Ordering checks come first, so the width/height values are only
    // trusted when they cannot have wrapped.
    w_valid  = (r_cur.right > r_cur.left) && (r_cur.down > r_cur.up) &&
               (w_width >= MIN_W_D) && (w_width <= MAX_W_D) &&
               (w_height >= MIN_H_D);
    w_stable = (abs_diff(r_cur.left,  r_prev.left)  <= JITTER_D) &&
               (abs_diff(r_cur.right, r_prev.right) <= JITTER_D) &&
               (abs_diff(r_cur.up,    r_prev.up)    <= JITTER_D) &&
               (abs_diff(r_cur.down,  r_prev.down)  <= JITTER_D);
    w_cnt_next = 4'd0;
    if (w_valid) begin
      if (!w_stable)        w_cnt_next = 4'd1;
      else if (r_cnt >= SF) w_cnt_next = SF;
      else                  w_cnt_next = r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_latch   <= 1'b0;
      r_cur     <= '0;
      r_prev    <= '0;
      r_cnt     <= 4'd0;
    end else begin
      r_vs_prev <= i_vs;
      r_latch   <= w_rise;
      if (w_rise) begin
        r_prev <= r_cur;
        r_cur  <= i_edges;
      end
      if (r_latch) r_cnt <= w_cnt_next;
    end
  end

  assign o_box    = r_cur;
  assign o_box_on = (r_cnt == SF);

endmodule

// File: rtl/plate_box_overlay.sv
// plate_box_overlay: draws a rectangle around the located plate onto an
// RGB888 stream once the box has been valid and stable for enough frames.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   i_hs, i_vs, i_de           input syncs / data enable (i_vs high = active)
//   i_x, i_y, i_data           input coordinates and RGB888 pixel
//   edge_left/right/up/down    box edges from the character-location stage
//   o_data, o_x, o_y           overlaid pixel and coordinates, 2 cycles late
//   o_hs, o_vs, o_de           syncs delayed by 2 cycles
//   o_box_on                   overlay currently enabled
module plate_box_overlay
  import plate_pkg::*;
#(
  parameter int               BOX_T         = 2,
  parameter logic [RGB_W-1:0] BOX_COLOR     = C_RED,
  parameter int               MIN_W         = 40,
  parameter int               MAX_W         = 380,
  parameter int               MIN_H         = 20,
  parameter int               JITTER        = 4,
  parameter int               STABLE_FRAMES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [RGB_W-1:0]   i_data,
  input  logic [COORD_W-1:0] edge_left,
  input  logic [COORD_W-1:0] edge_right,
  input  logic [COORD_W-1:0] edge_up,
  input  logic [COORD_W-1:0] edge_down,
  output logic [RGB_W-1:0]   o_data,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_box_on
);

  localparam logic [DIFF_W-1:0] T_M1 = DIFF_W'(BOX_T - 1);

  box_t              w_edges;
  box_t              w_box;
  logic              w_box_on;
  logic [DIFF_W-1:0] w_x, w_y, w_l, w_r, w_u, w_d;
  logic              w_in_x, w_in_y, w_vbar, w_hbar;

  // Stage 1
  logic [RGB_W-1:0]   r_data1;
  logic [COORD_W-1:0] r_x1, r_y1;
  logic               r_hs1, r_vs1, r_de1, r_border1, r_box_on1;
  // Stage 2 (outputs)
  logic [RGB_W-1:0]   r_data2;
  logic [COORD_W-1:0] r_x2, r_y2;
  logic               r_hs2, r_vs2, r_de2;

  assign w_edges = '{left: edge_left, right: edge_right, up: edge_up, down: edge_down};

  box_stability_filter #(
    .MIN_W         (MIN_W),
    .MAX_W         (MAX_W),
    .MIN_H         (MIN_H),
    .JITTER        (JITTER),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_vs     (i_vs),
    .i_edges  (w_edges),
    .o_box    (w_box),
    .o_box_on (w_box_on)
  );

  // All geometry in 13 bits. The far-side bars are tested as x+T-1 >= right
  // rather than x >= right-T+1 so nothing can underflow either way.
  always_comb begin
    w_x    = {1'b0, i_x};
    w_y    = {1'b0, i_y};
    w_l    = {1'b0, w_box.left};
    w_r    = {1'b0, w_box.right};
    w_u    = {1'b0, w_box.up};
    w_d    = {1'b0, w_box.down};
    w_in_x = (w_x >= w_l) && (w_x <= w_r);
    w_in_y = (w_y >= w_u) && (w_y <= w_d);
    w_vbar = w_in_y && (((w_x >= w_l) && (w_x <= w_l + T_M1)) ||
                        ((w_x + T_M1 >= w_r) && (w_x <= w_r)));
    w_hbar = w_in_x && (((w_y >= w_u) && (w_y <= w_u + T_M1)) ||
                        ((w_y + T_M1 >= w_d) && (w_y <= w_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data1   <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_de1     <= 1'b0;
      r_border1 <= 1'b0;
      r_box_on1 <= 1'b0;
      r_data2   <= '0;
      r_x2      <= '0;
      r_y2      <= '0;
      r_hs2     <= 1'b0;
      r_vs2     <= 1'b0;
      r_de2     <= 1'b0;
    end else begin
      r_data1   <= i_data;
      r_x1      <= i_x;
      r_y1      <= i_y;
      r_hs1     <= i_hs;
      r_vs1     <= i_vs;
      r_de1     <= i_de;
      r_border1 <= w_vbar | w_hbar;
      r_box_on1 <= w_box_on;
      r_data2   <= (r_border1 && r_de1 && r_box_on1) ? BOX_COLOR : r_data1;
      r_x2      <= r_x1;
      r_y2      <= r_y1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_de2     <= r_de1;
    end
  end

  assign o_data   = r_data2;
  assign o_x      = r_x2;
  assign o_y      = r_y2;
  assign o_hs     = r_hs2;
  assign o_vs     = r_vs2;
  assign o_de     = r_de2;
  assign o_box_on = w_box_on;

endmodule

// File: tb/tb_plate_box_overlay.sv
// Directed bench for plate_box_overlay. Two instances share the stimulus:
// u_std uses the default MAX_W=380, u_wide uses MAX_W=4095 for the
// full-screen box case. Expected pixels are pushed to a scoreboard when
// driven and compared two cycles later.
module tb_plate_box_overlay;
  import plate_pkg::*;

  typedef struct packed {
    logic [23:0] data;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        de;
  } vid_t;

  typedef struct {
    vid_t e0;
    vid_t e1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [11:0] i_x = '0, i_y = '0;
  logic [23:0] i_data = '0;
  logic [11:0] edge_left = '0, edge_right = '0, edge_up = '0, edge_down = '0;

  logic [23:0] o_data0, o_data1;
  logic [11:0] o_x0, o_y0, o_x1, o_y1;
  logic        o_hs0, o_vs0, o_de0, o_box_on0;
  logic        o_hs1, o_vs1, o_de1, o_box_on1;
  vid_t        obs0, obs1;

  assign obs0 = {o_data0, o_x0, o_y0, o_hs0, o_vs0, o_de0};
  assign obs1 = {o_data1, o_x1, o_y1, o_hs1, o_vs1, o_de1};

  plate_box_overlay u_std (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up), .edge_down(edge_down),
    .o_data(o_data0), .o_x(o_x0), .o_y(o_y0), .o_hs(o_hs0), .o_vs(o_vs0), .o_de(o_de0),
    .o_box_on(o_box_on0)
  );

  plate_box_overlay #(.MAX_W(4095)) u_wide (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up), .edge_down(edge_down),
    .o_data(o_data1), .o_x(o_x1), .o_y(o_y1), .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1),
    .o_box_on(o_box_on1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  bit   last_vs = 1'b0;

  // Model state per instance: [k][0..3] = left, right, up, down
  int m_cur[2][4];
  int m_prev[2][4];
  int m_cnt[2];
  int m_maxw[2] = '{380, 4095};

  // Probe pixels: x, y, de
  int px[18] = '{100, 200, 102, 200,  99, 300, 301, 150, 150,
                   0,   1,   2, 4094, 4095, 4093, 200, 100, 100};
  int py[18] = '{120,  81, 120,  82, 120, 120, 120, 160, 161,
                  50,  50,  50,  50,  50,  50,  80, 120, 121};
  bit pd[18] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};

  task automatic cmp_vid(input string tag, input vid_t obs, input vid_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit m_border(input int k, input int x, input int y);
    int l, r, u, d;
    bit vb, hb;
    l = m_cur[k][0]; r = m_cur[k][1]; u = m_cur[k][2]; d = m_cur[k][3];
    vb = (y >= u) && (y <= d) && (((x >= l) && (x <= l + 1)) || ((x >= r - 1) && (x <= r)));
    hb = (x >= l) && (x <= r) && (((y >= u) && (y <= u + 1)) || ((y >= d - 1) && (y <= d)));
    return vb || hb;
  endfunction

  task automatic model_latch();
    for (int k = 0; k < 2; k++) begin
      int w, h;
      bit valid, stable;
      for (int e = 0; e < 4; e++) m_prev[k][e] = m_cur[k][e];
      m_cur[k][0] = int'(edge_left);
      m_cur[k][1] = int'(edge_right);
      m_cur[k][2] = int'(edge_up);
      m_cur[k][3] = int'(edge_down);
      w = m_cur[k][1] - m_cur[k][0];
      h = m_cur[k][3] - m_cur[k][2];
      valid = (w > 0) && (h > 0) && (w >= 40) && (w <= m_maxw[k]) && (h >= 20);
      stable = 1'b1;
      for (int e = 0; e < 4; e++) begin
        int dd;
        dd = m_cur[k][e] - m_prev[k][e];
        if (dd < 0) dd = -dd;
        if (dd > 4) stable = 1'b0;
      end
      if (!valid)       m_cnt[k] = 0;
      else if (!stable) m_cnt[k] = 1;
      else if (m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < 4; e++) begin
        m_cur[k][e] = 0;
        m_prev[k][e] = 0;
      end
      m_cnt[k] = 0;
    end
    sb.delete();
    last_vs = 1'b0;
  endtask

  task automatic check_zero();
    cmp_vid("rst_std", obs0, '0);
    cmp_vid("rst_wide", obs1, '0);
    cmp_bit("rst_box_std", o_box_on0, 1'b0);
    cmp_bit("rst_box_wide", o_box_on1, 1'b0);
  endtask

  // One pixel cycle: compare the pixel driven two steps ago, then drive.
  task automatic step(input int x, input int y, input bit de, input bit hs,
                      input bit vs, input bit chk_box);
    exp_t e;
    vid_t ev;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      cmp_vid("vid_std", obs0, e.e0);
      cmp_vid("vid_wide", obs1, e.e1);
    end
    if (chk_box) begin
      cmp_bit("box_on_std", o_box_on0, m_cnt[0] == 3);
      cmp_bit("box_on_wide", o_box_on1, m_cnt[1] == 3);
    end
    i_x = 12'(x);
    i_y = 12'(y);
    i_de = de;
    i_hs = hs;
    i_vs = vs;
    i_data = 24'($urandom);
    for (int k = 0; k < 2; k++) begin
      ev = '{data: i_data, x: i_x, y: i_y, hs: hs, vs: vs, de: de};
      if (de && (m_cnt[k] == 3) && m_border(k, x, y)) ev.data = 24'hFF0000;
      if (k == 0) e.e0 = ev; else e.e1 = ev;
    end
    sb.push_back(e);
    if (vs && !last_vs) model_latch();
    last_vs = vs;
  endtask

  // Blanking, vs rise with two quiet cycles, then the probe pixels. At probe
  // index 8 the edge inputs switch to the second set, mid-frame.
  task automatic frame(input int l, input int r, input int u, input int d,
                       input int l2, input int r2, input int u2, input int d2);
    edge_left = 12'(l); edge_right = 12'(r); edge_up = 12'(u); edge_down = 12'(d);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin
        edge_left = 12'(l2); edge_right = 12'(r2); edge_up = 12'(u2); edge_down = 12'(d2);
      end
      step(px[i], py[i], pd[i], i[0], 1'b1, 1'b1);
    end
  endtask

  task automatic frames(input int n, input int l, input int r, input int u, input int d);
    for (int i = 0; i < n; i++) frame(l, r, u, d, l, r, u, d);
  endtask

  task automatic reset_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_x = 12'($urandom); i_y = 12'($urandom); i_data = 24'($urandom);
      i_de = 1'($urandom); i_hs = 1'($urandom); i_vs = 1'($urandom);
      #1;
      check_zero();
    end
  endtask

  initial begin
    model_reset();
    edge_left = 12'd100; edge_right = 12'd300; edge_up = 12'd80; edge_down = 12'd160;
    reset_hold(5);
    @(negedge clk);
    i_vs = 1'b0; i_de = 1'b0;
    rst_n = 1'b1;

    frames(3, 100, 300, 80, 160);   // box appears in frame 3
    frames(1, 100, 300, 80, 160);   // saturated
    frames(3, 100, 306, 80, 160);   // jump of 6: restart at 1, on again at 3rd
    frames(1, 100, 303, 80, 160);   // jump of 3: stays on
    frames(1, 300, 100, 80, 160);   // reversed edges: off
    frames(3, 100, 300, 80, 160);
    frames(1, 100, 130, 80, 160);   // width 30: off
    frames(3, 100, 300, 80, 160);
    frames(1, 100, 300, 80, 90);    // height 10: off
    frames(3, 100, 300, 80, 160);
    frame(100, 300, 80, 160, 102, 302, 82, 162);  // mid-frame change ignored
    frames(1, 102, 302, 82, 162);   // new box used from here
    frames(3, 0, 4095, 0, 4095);    // full-screen box: only u_wide accepts it

    // Asynchronous reset in the middle of an active frame.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero();
    model_reset();
    reset_hold(3);
    @(negedge clk);
    i_vs = 1'b0; i_de = 1'b0;
    rst_n = 1'b1;
    frames(3, 100, 300, 80, 160);

    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
